// File: rtl/cr_kme_unpack_pkg.sv
// Shared types and helpers for the KME FIFO unpacker.
// Optional feature macro used by the top: CR_KME_UNPACK_PERF_EN.
package cr_kme_unpack_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_e;

    localparam int ERR_OVF = 1;
    localparam int ERR_UNF = 0;

    function automatic int n_beats(input int in_w, input int out_w);
        return in_w / out_w;
    endfunction

endpackage

// File: rtl/cr_kme_unpack_perf.sv
// Free-running 32-bit word and stall counters for the unpacker.
// Instantiated only when CR_KME_UNPACK_PERF_EN is defined; cleared by rst only.
module cr_kme_unpack_perf (
    input  logic        clk,
    input  logic        rst,
    input  logic        word_inc,
    input  logic        stall_inc,
    output logic [31:0] perf_words,
    output logic [31:0] perf_stalls
);

    logic [31:0] words_q, words_d;
    logic [31:0] stalls_q, stalls_d;

    // Next-count logic; both counters wrap naturally at 2^32.
    always_comb begin
        words_d  = words_q;
        stalls_d = stalls_q;
        if (word_inc) begin
            words_d = words_q + 32'd1;
        end else begin
            words_d = words_q;
        end
        if (stall_inc) begin
            stalls_d = stalls_q + 32'd1;
        end else begin
            stalls_d = stalls_q;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            words_q  <= 32'd0;
            stalls_q <= 32'd0;
        end else begin
            words_q  <= words_d;
            stalls_q <= stalls_d;
        end
    end

    assign perf_words  = words_q;
    assign perf_stalls = stalls_q;

endmodule

// File: rtl/cr_kme_fifo_unpacker.sv
// Pops 128-bit KME staging FIFO words and serialises them into OUT_W beats, LSB slice first.
// Optional perf counters are built only when CR_KME_UNPACK_PERF_EN is defined.
module cr_kme_fifo_unpacker
    import cr_kme_unpack_pkg::*;
#(
    parameter int IN_W  = 128,
    parameter int OUT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IN_W-1:0]  fifo_out,
    input  logic             fifo_out_valid,
    output logic             fifo_out_ack,
    input  logic             fifo_overflow,
    input  logic             fifo_underflow,
    input  logic             flush,
    output logic [OUT_W-1:0] beat_data,
    output logic             beat_valid,
    input  logic             beat_ready,
    output logic             beat_first,
    output logic             beat_last,
    output logic [1:0]       err_sticky,
    input  logic             err_clr,
    output logic [31:0]      perf_words,
    output logic [31:0]      perf_stalls
);

    localparam int N_BEATS = n_beats(IN_W, OUT_W);
    localparam int IDX_W   = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BEATS - 1);

    state_e                        state_q, state_d;
    logic [IN_W-1:0]               hold_q, hold_d;
    logic [IDX_W-1:0]              beat_idx_q, beat_idx_d;
    logic [1:0]                    err_q, err_d;
    logic [N_BEATS-1:0][OUT_W-1:0] hold_beats_s;
    logic                          hold_valid_s;
    logic                          is_last_s;
    logic                          xfer_s;
    logic                          ack_s;

    assign hold_valid_s = (state_q == ACTIVE);
    assign is_last_s    = (beat_idx_q == LAST_IDX);
    assign xfer_s       = hold_valid_s & beat_ready;
    // Gating with rst keeps the FIFO from being popped while the held word is being discarded.
    assign ack_s        = fifo_out_valid & ~flush & ~rst & (~hold_valid_s | (xfer_s & is_last_s));
    assign hold_beats_s = hold_q;

    // Word hold / beat sequencing; flush outranks a pop, which outranks a plain beat advance.
    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        beat_idx_d = beat_idx_q;
        if (flush) begin
            state_d    = IDLE;
            beat_idx_d = '0;
        end else if (ack_s) begin
            hold_d     = fifo_out;
            beat_idx_d = '0;
            state_d    = ACTIVE;
        end else if (xfer_s) begin
            if (is_last_s) begin
                beat_idx_d = '0;
                state_d    = IDLE;
            end else begin
                beat_idx_d = beat_idx_q + IDX_W'(1);
            end
        end else begin
            state_d = state_q;
        end
    end

    // Sticky error flags; a set in the same cycle as err_clr wins.
    always_comb begin
        err_d = err_clr ? 2'b00 : err_q;
        if (fifo_overflow) begin
            err_d[ERR_OVF] = 1'b1;
        end else begin
            err_d[ERR_OVF] = err_d[ERR_OVF];
        end
        if (fifo_underflow) begin
            err_d[ERR_UNF] = 1'b1;
        end else begin
            err_d[ERR_UNF] = err_d[ERR_UNF];
        end
    end

    // State, hold and error registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            hold_q     <= '0;
            beat_idx_q <= '0;
            err_q      <= 2'b00;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            beat_idx_q <= beat_idx_d;
            err_q      <= err_d;
        end
    end

    assign fifo_out_ack = ack_s;
    assign beat_valid   = hold_valid_s;
    assign beat_data    = hold_beats_s[beat_idx_q];
    assign beat_first   = hold_valid_s & (beat_idx_q == '0);
    assign beat_last    = hold_valid_s & is_last_s;
    assign err_sticky   = err_q;

`ifdef CR_KME_UNPACK_PERF_EN
    cr_kme_unpack_perf u_perf (
        .clk         (clk),
        .rst         (rst),
        .word_inc    (ack_s),
        .stall_inc   (hold_valid_s & ~beat_ready),
        .perf_words  (perf_words),
        .perf_stalls (perf_stalls)
    );
`else
    assign perf_words  = 32'd0;
    assign perf_stalls = 32'd0;
`endif

endmodule
